// File: rtl/circ_buffer_param.sv
// Parametrised single-clock circular FIFO with occupancy count, almost
// thresholds, a read-valid strobe, an undo (clear) command and encoded
// error reporting.
//
// Command handshake: wr_en/rd_en/clear are sampled on every rising CLK
// edge with no back-pressure. A rejected command leaves all state alone
// and raises error for exactly one cycle; err_code keeps the cause until
// the next rejection. rd_valid pulses for one cycle whenever rd_data was
// loaded by that edge.
module circ_buffer_param #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic                       clear,
   input  logic [DATA_W-1:0]          wr_data,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   output logic                       fifo_empty,
   output logic                       fifo_full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       error,
   output logic [2:0]                 err_code
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
   localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
   localparam logic [2:0] ERR_ILLEGAL   = 3'd3;
   localparam logic [2:0] ERR_UNDO      = 3'd4;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_error;
   logic [2:0]        r_err_code;

   logic              w_empty;
   logic              w_full;
   logic              w_illegal;
   logic              w_wr_only;
   logic              w_rd_only;
   logic              w_both;
   logic              w_clr_only;
   logic              w_push;
   logic              w_pop;
   logic              w_bypass;
   logic              w_undo;
   logic              w_err;
   logic [2:0]        w_err_code;

   // Pointers wrap explicitly so any DEPTH works, not just powers of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? LAST_PTR : p - 1'b1;
   endfunction

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);

   // Command decode: clear may not be combined with anything else.
   assign w_illegal  = clear & (wr_en | rd_en);
   assign w_wr_only  = wr_en & ~rd_en & ~clear;
   assign w_rd_only  = rd_en & ~wr_en & ~clear;
   assign w_both     = wr_en & rd_en & ~clear;
   assign w_clr_only = clear & ~wr_en & ~rd_en;

   // A simultaneous write+read on a non-empty buffer (even full) moves both
   // pointers; on an empty buffer the write data goes straight to rd_data.
   assign w_push   = (w_wr_only & ~w_full) | (w_both & ~w_empty);
   assign w_pop    = (w_rd_only & ~w_empty) | (w_both & ~w_empty);
   assign w_bypass = w_both & w_empty;
   assign w_undo   = w_clr_only & ~w_empty;

   assign w_err = (w_wr_only & w_full) | (w_rd_only & w_empty) |
                  (w_clr_only & w_empty) | w_illegal;

   assign w_err_code = w_illegal               ? ERR_ILLEGAL   :
                       (w_wr_only & w_full)    ? ERR_OVERFLOW  :
                       (w_rd_only & w_empty)   ? ERR_UNDERFLOW :
                       (w_clr_only & w_empty)  ? ERR_UNDO      : 3'd0;

   // Storage array: written at the tail, never reset (pointers define validity).
   always_ff @(posedge CLK) begin
      if (w_push && !RESET) begin
         r_mem[r_tail] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_pop)  r_head <= ptr_inc(r_head);
         if (w_push) r_tail <= ptr_inc(r_tail);
         if (w_undo) r_tail <= ptr_dec(r_tail);
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if ((w_pop && !w_push) || w_undo)
            r_count <= r_count - 1'b1;
      end
   end

   // Registered read data and its one-cycle valid strobe.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop | w_bypass;
         if (w_pop)
            r_rd_data <= r_mem[r_head];
         else if (w_bypass)
            r_rd_data <= wr_data;
      end
   end

   // Error pulse; the cause code is held until the next rejected command.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_error    <= 1'b0;
         r_err_code <= 3'd0;
      end else begin
         r_error <= w_err;
         if (w_err) r_err_code <= w_err_code;
      end
   end

   assign rd_data      = r_rd_data;
   assign rd_valid     = r_rd_valid;
   assign count        = r_count;
   assign error        = r_error;
   assign err_code     = r_err_code;
   assign fifo_empty   = w_empty;
   assign fifo_full    = w_full;
   assign almost_empty = (int'(r_count) <= AE_LEVEL);
   assign almost_full  = (int'(r_count) >= AF_LEVEL);

endmodule

// File: tb/tb_circ_buffer_param.sv
// Bench for circ_buffer_param: one DEPTH=8 and one DEPTH=5 instance share
// the same command stream; each has its own list-based reference model and
// expected-response queue checked by a negedge monitor.
module tb_circ_buffer_param;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
    logic       err;
    logic [2:0] code;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       ae;
    logic       af;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, clr;
  logic [7:0] wr_data;

  logic [7:0] rd_data_8, rd_data_5;
  logic       rd_valid_8, rd_valid_5;
  logic       empty_8, empty_5, full_8, full_5;
  logic       ae_8, ae_5, af_8, af_5;
  logic [3:0] count_8;
  logic [2:0] count_5;
  logic       error_8, error_5;
  logic [2:0] code_8, code_5;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model: plain ordered list per instance, front = oldest
  logic [7:0] mlist [2][0:15];
  int         mlen  [2];
  logic [7:0] mrd   [2];
  logic [2:0] mcode [2];

  exp_t exp_q8[$];
  exp_t exp_q5[$];

  circ_buffer_param #(.DATA_W(8), .DEPTH(8)) u_d8 (
    .CLK(clk), .RESET(rst), .wr_en(wr_en), .rd_en(rd_en), .clear(clr),
    .wr_data(wr_data), .rd_data(rd_data_8), .rd_valid(rd_valid_8),
    .fifo_empty(empty_8), .fifo_full(full_8), .almost_empty(ae_8),
    .almost_full(af_8), .count(count_8), .error(error_8), .err_code(code_8)
  );

  circ_buffer_param #(.DATA_W(8), .DEPTH(5)) u_d5 (
    .CLK(clk), .RESET(rst), .wr_en(wr_en), .rd_en(rd_en), .clear(clr),
    .wr_data(wr_data), .rd_data(rd_data_5), .rd_valid(rd_valid_5),
    .fifo_empty(empty_5), .fifo_full(full_5), .almost_empty(ae_5),
    .almost_full(af_5), .count(count_5), .error(error_5), .err_code(code_5)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mlen[k]  = 0;
      mrd[k]   = 8'h00;
      mcode[k] = 3'd0;
    end
  endtask

  task automatic model_step(input int k, input logic w, input logic r,
                            input logic c, input logic [7:0] d, output exp_t e);
    int dk;
    dk    = (k == 0) ? 8 : 5;
    e     = '0;
    if (c && (w || r)) begin
      e.err = 1'b1; mcode[k] = 3'd3;
    end else if (c) begin
      if (mlen[k] == 0) begin e.err = 1'b1; mcode[k] = 3'd4; end
      else mlen[k]--;
    end else if (w && r) begin
      e.vld = 1'b1;
      if (mlen[k] == 0) mrd[k] = d;
      else begin
        mrd[k] = mlist[k][0];
        for (int i = 0; i < mlen[k] - 1; i++) mlist[k][i] = mlist[k][i+1];
        mlist[k][mlen[k]-1] = d;
      end
    end else if (w) begin
      if (mlen[k] == dk) begin e.err = 1'b1; mcode[k] = 3'd1; end
      else begin mlist[k][mlen[k]] = d; mlen[k]++; end
    end else if (r) begin
      if (mlen[k] == 0) begin e.err = 1'b1; mcode[k] = 3'd2; end
      else begin
        e.vld  = 1'b1;
        mrd[k] = mlist[k][0];
        for (int i = 0; i < mlen[k] - 1; i++) mlist[k][i] = mlist[k][i+1];
        mlen[k]--;
      end
    end
    e.data = mrd[k];
    e.code = mcode[k];
    e.cnt  = 4'(mlen[k]);
    e.emp  = (mlen[k] == 0);
    e.ful  = (mlen[k] == dk);
    e.ae   = (mlen[k] <= 2);
    e.af   = (mlen[k] >= dk - 2);
  endtask

  // driver: one command per clock, inputs changed away from the rising edge
  task automatic do_cmd(input logic w, input logic r, input logic c, input logic [7:0] d);
    exp_t e8, e5;
    @(negedge clk);
    wr_en = w; rd_en = r; clr = c; wr_data = d;
    @(posedge clk);
    model_step(0, w, r, c, d, e8);
    model_step(1, w, r, c, d, e5);
    exp_q8.push_back(e8);
    exp_q5.push_back(e5);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " d8 count"}, 16'(count_8), 16'd0);
    chk({tag, " d8 empty"}, 16'(empty_8), 16'd1);
    chk({tag, " d8 full"}, 16'(full_8), 16'd0);
    chk({tag, " d8 ae"}, 16'(ae_8), 16'd1);
    chk({tag, " d8 af"}, 16'(af_8), 16'd0);
    chk({tag, " d8 rd_valid"}, 16'(rd_valid_8), 16'd0);
    chk({tag, " d8 rd_data"}, 16'(rd_data_8), 16'd0);
    chk({tag, " d8 error"}, 16'(error_8), 16'd0);
    chk({tag, " d8 err_code"}, 16'(code_8), 16'd0);
    chk({tag, " d5 count"}, 16'(count_5), 16'd0);
    chk({tag, " d5 empty"}, 16'(empty_5), 16'd1);
    chk({tag, " d5 af"}, 16'(af_5), 16'd0);
    chk({tag, " d5 error"}, 16'(error_5), 16'd0);
    chk({tag, " d5 err_code"}, 16'(code_5), 16'd0);
  endtask

  task automatic check_rec(input string tag, input exp_t e, input logic vld,
                           input logic [7:0] data, input logic err, input logic [2:0] code,
                           input logic [3:0] cnt, input logic emp, input logic ful,
                           input logic ae, input logic af);
    chk({tag, " rd_valid"}, 16'(vld), 16'(e.vld));
    chk({tag, " rd_data"}, 16'(data), 16'(e.data));
    chk({tag, " error"}, 16'(err), 16'(e.err));
    chk({tag, " err_code"}, 16'(code), 16'(e.code));
    chk({tag, " count"}, 16'(cnt), 16'(e.cnt));
    chk({tag, " empty"}, 16'(emp), 16'(e.emp));
    chk({tag, " full"}, 16'(ful), 16'(e.ful));
    chk({tag, " almost_empty"}, 16'(ae), 16'(e.ae));
    chk({tag, " almost_full"}, 16'(af), 16'(e.af));
  endtask

  // monitor: registered outputs sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q8.size() > 0) begin
      e = exp_q8.pop_front();
      check_rec("d8", e, rd_valid_8, rd_data_8, error_8, code_8, count_8,
                empty_8, full_8, ae_8, af_8);
    end
    if (exp_q5.size() > 0) begin
      e = exp_q5.pop_front();
      check_rec("d5", e, rd_valid_5, rd_data_5, error_5, code_5, {1'b0, count_5},
                empty_5, full_5, ae_5, af_5);
    end
  end

  task automatic random_ops(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      do_cmd(1, 0, 0, 8'($urandom_range(0, 255)));
      else if (r < 72) do_cmd(0, 1, 0, 8'h00);
      else if (r < 84) do_cmd(1, 1, 0, 8'($urandom_range(0, 255)));
      else if (r < 92) do_cmd(0, 0, 1, 8'h00);
      else if (r < 95) do_cmd(1, 0, 1, 8'($urandom_range(0, 255)));
      else if (r < 97) do_cmd(0, 1, 1, 8'h00);
      else             do_cmd(0, 0, 0, 8'h00);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // fill, then overflow
    for (int i = 1; i <= 8; i++) do_cmd(1, 0, 0, 8'(i * 8'h11));
    do_cmd(1, 0, 0, 8'h99);
    // drain in order, then underflow
    for (int i = 0; i < 9; i++) do_cmd(0, 1, 0, 8'h00);
    // bypass on empty
    do_cmd(1, 1, 0, 8'h5A);
    // bypass on full, then drain so 0xC3 comes out last
    for (int i = 1; i <= 8; i++) do_cmd(1, 0, 0, 8'(8'h20 + i));
    do_cmd(1, 1, 0, 8'hC3);
    for (int i = 0; i < 8; i++) do_cmd(0, 1, 0, 8'h00);
    // undo the newest write
    do_cmd(1, 0, 0, 8'hA1); do_cmd(1, 0, 0, 8'hA2); do_cmd(1, 0, 0, 8'hA3);
    do_cmd(0, 0, 1, 8'h00);
    do_cmd(0, 1, 0, 8'h00); do_cmd(0, 1, 0, 8'h00);
    do_cmd(0, 0, 1, 8'h00);
    // illegal clear combinations
    do_cmd(1, 0, 1, 8'h77);
    do_cmd(0, 1, 1, 8'h00);
    do_cmd(1, 1, 1, 8'h78);
    do_cmd(0, 1, 0, 8'h00);
    do_cmd(0, 0, 0, 8'h00);
    // interleaved writes/reads to wrap the pointers of both depths
    for (int i = 0; i < 12; i++) begin
      do_cmd(1, 0, 0, 8'(8'hB0 + i));
      if (i % 3 != 2) do_cmd(0, 1, 0, 8'h00);
    end
    random_ops(300);

    // reset mid-stream: takes effect without a clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async reset");
    wr_en = 1'b1; rd_en = 1'b1; clr = 1'b1; wr_data = 8'hEE;
    @(posedge clk);
    #1 check_reset_values("cmds in reset");
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    rst = 1'b0;
    model_reset();

    random_ops(300);
    repeat (3) @(negedge clk);
    chk("d8 drain", 16'(exp_q8.size()), 16'd0);
    chk("d5 drain", 16'(exp_q5.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
